// File: rtl/ahb_policy_cfg.sv
// ---------------------------------------------------------------------------
// ahb_policy_cfg
//
// AHB-lite slave register file holding the APU/DPU security policies that the
// transaction monitor consumes. Only trusted masters (hmaster[31:1] == 0) may
// write. The block provides a sticky LOCK and an 8-bit saturating error
// counter. Illegal accesses get the standard two-cycle AHB ERROR response.
//
// Optional build macro: POLICY_SHADOW_EN
//   defined   : policy writes land in shadow registers; a write of 1 to COMMIT
//               (0x80C) copies all shadows to the policy outputs in one cycle.
//   undefined : policy writes drive the outputs directly; 0x80C is unmapped.
//
// Ports
//   hclk, hresetn      clock, asynchronous active-low reset
//   hsel               slave select
//   haddr[31:0]        byte address (only [11:0] decoded)
//   hmaster[31:0]      requesting master ID
//   hsize[2:0]         transfer size (only word accesses are legal)
//   hwdata[31:0]       write data (data phase)
//   hwrite             1 = write
//   hrdata[31:0]       read data (0 unless the data phase is a legal read)
//   hready             transfer done / stall
//   hresp              1 = ERROR
//   apumid/apuaddr/apumask/apuperm           [NUM_APU_POLICY] x 32 policies
//   dpumid/dpuaddr/dpudata/dpumask/dpuamask  [NUM_DPU_POLICY] x 32 policies
//
// Address map (haddr[11:0])
//   0x000 + 16*i : APU entry i  (+0 mid, +4 addr, +8 mask, +C perm)
//   0x400 + 32*j : DPU entry j  (+0 mid, +4 addr, +8 data, +C mask, +10 amask)
//   0x800 CTRL   (RW)  bit0 LOCK, sticky until reset
//   0x804 STATUS (RO)  bit0 LOCK, [15:8] ERRCNT
//   0x808 ERRCLR (WO)  any accepted write clears ERRCNT (reads 0)
//   0x80C COMMIT (WO)  only with POLICY_SHADOW_EN (reads 0)
// ---------------------------------------------------------------------------
module ahb_policy_cfg #(
    parameter int NUM_MASTERS    = 16,
    parameter int NUM_APU_POLICY = NUM_MASTERS,
    parameter int NUM_DPU_POLICY = NUM_MASTERS
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [31:0] hmaster,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hwrite,
    output logic [31:0] hrdata,
    output logic        hready,
    output logic        hresp,
    output logic [31:0] apumid   [NUM_APU_POLICY],
    output logic [31:0] apuaddr  [NUM_APU_POLICY],
    output logic [31:0] apumask  [NUM_APU_POLICY],
    output logic [31:0] apuperm  [NUM_APU_POLICY],
    output logic [31:0] dpumid   [NUM_DPU_POLICY],
    output logic [31:0] dpuaddr  [NUM_DPU_POLICY],
    output logic [31:0] dpudata  [NUM_DPU_POLICY],
    output logic [31:0] dpumask  [NUM_DPU_POLICY],
    output logic [31:0] dpuamask [NUM_DPU_POLICY]
);

    typedef enum logic [2:0] {
        K_NONE, K_APU, K_DPU, K_CTRL, K_STAT, K_ERRCLR, K_COMMIT
    } kind_e;

    typedef enum logic [1:0] {S_IDLE, S_ERR1, S_ERR2} state_e;

    localparam logic [6:0] APU_N = 7'(NUM_APU_POLICY);
    localparam logic [5:0] DPU_N = 6'(NUM_DPU_POLICY);

    // Classify a word address; anything unmapped, reserved or past the last
    // configured entry returns K_NONE.
    function automatic kind_e f_kind(input logic [11:0] a);
        kind_e k;
        k = K_NONE;
        case (a[11:10])
            2'b00: if ({1'b0, a[9:4]} < APU_N) k = K_APU;
            2'b01: if (({1'b0, a[9:5]} < DPU_N) && (a[4:2] <= 3'd4)) k = K_DPU;
            2'b10: begin
                case (a[9:2])
                    8'h00:   k = K_CTRL;
                    8'h01:   k = K_STAT;
                    8'h02:   k = K_ERRCLR;
`ifdef POLICY_SHADOW_EN
                    8'h03:   k = K_COMMIT;
`endif
                    default: k = K_NONE;
                endcase
            end
            default: k = K_NONE;
        endcase
        return k;
    endfunction

    // Response FSM and data-phase state
    state_e      r_state;
    state_e      w_next_state;
    logic        r_dp_wr;        // data phase of a legal write
    logic        r_dp_rd;        // data phase of a legal read
    logic [11:0] r_dp_addr;

    // Control / status
    logic        r_lock;
    logic [7:0]  r_errcnt;

    // Programmed policy values (shadows when POLICY_SHADOW_EN is defined)
    logic [31:0] r_amid   [NUM_APU_POLICY];
    logic [31:0] r_aaddr  [NUM_APU_POLICY];
    logic [31:0] r_amask  [NUM_APU_POLICY];
    logic [31:0] r_aperm  [NUM_APU_POLICY];
    logic [31:0] r_dmid   [NUM_DPU_POLICY];
    logic [31:0] r_daddr  [NUM_DPU_POLICY];
    logic [31:0] r_ddata  [NUM_DPU_POLICY];
    logic [31:0] r_dmask  [NUM_DPU_POLICY];
    logic [31:0] r_damask [NUM_DPU_POLICY];

    kind_e       w_ap_kind;
    kind_e       w_dp_kind;
    logic        w_take;
    logic        w_trusted;
    logic        w_lock_eff;
    logic        w_lockable;
    logic        w_illegal;
    logic        w_wr_apu;
    logic        w_wr_dpu;
    logic        w_set_lock;
    logic        w_errclr;
    logic [5:0]  w_dp_aidx;
    logic [4:0]  w_dp_didx;
    logic        w_unused;

    // ---------------- address-phase check ----------------
    assign w_ap_kind = f_kind(haddr[11:0]);
    assign w_dp_kind = f_kind(r_dp_addr);
    assign w_take    = hsel && hready;
    assign w_trusted = (hmaster[31:1] == 31'd0);

    // A CTRL write whose data phase overlaps this address phase must lock out
    // a back-to-back policy write, so the pending hwdata bit is folded in.
    assign w_set_lock = r_dp_wr && (w_dp_kind == K_CTRL) && hwdata[0];
    assign w_lock_eff = r_lock || w_set_lock;
    assign w_lockable = (w_ap_kind == K_APU) || (w_ap_kind == K_DPU) ||
                        (w_ap_kind == K_CTRL) || (w_ap_kind == K_COMMIT);

    assign w_illegal = (hsize != 3'b010) || (haddr[1:0] != 2'b00) ||
                       (w_ap_kind == K_NONE) ||
                       (hwrite && (!w_trusted || (w_ap_kind == K_STAT) ||
                                   (w_lock_eff && w_lockable)));

    // ---------------- data-phase decode ----------------
    assign w_dp_aidx = r_dp_addr[9:4];
    assign w_dp_didx = r_dp_addr[9:5];
    assign w_wr_apu  = r_dp_wr && (w_dp_kind == K_APU);
    assign w_wr_dpu  = r_dp_wr && (w_dp_kind == K_DPU);
    assign w_errclr  = r_dp_wr && (w_dp_kind == K_ERRCLR);

    // NUM_MASTERS is informational only; the comparison keeps it referenced.
    assign w_unused = &{1'b0, haddr[31:12], (hmaster < 32'(NUM_MASTERS))};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    // No address is sampled in ERR1 because hready is low there.
    always_comb begin
        w_next_state = S_IDLE;
        case (r_state)
            S_ERR1:  w_next_state = S_ERR2;
            default: w_next_state = (w_take && w_illegal) ? S_ERR1 : S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        hready = (r_state != S_ERR1);
        hresp  = (r_state != S_IDLE);
    end

    // ---------------- address/data pipeline ----------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_dp_wr   <= 1'b0;
            r_dp_rd   <= 1'b0;
            r_dp_addr <= 12'd0;
        end else begin
            r_dp_wr <= w_take && !w_illegal && hwrite;
            r_dp_rd <= w_take && !w_illegal && !hwrite;
            if (w_take) r_dp_addr <= haddr[11:0];
        end
    end

    // ---------------- LOCK and ERRCNT ----------------
    // An ERRCLR completing in the same cycle as a new error wins; that error
    // is not counted.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_lock   <= 1'b0;
            r_errcnt <= 8'd0;
        end else begin
            if (w_set_lock) r_lock <= 1'b1;
            if (w_errclr)
                r_errcnt <= 8'd0;
            else if (w_take && w_illegal && (r_errcnt != 8'hFF))
                r_errcnt <= r_errcnt + 8'd1;
        end
    end

    // ---------------- policy write ----------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NUM_APU_POLICY; i++) begin
                r_amid[i]  <= '0;
                r_aaddr[i] <= '0;
                r_amask[i] <= '0;
                r_aperm[i] <= '0;
            end
        end else if (w_wr_apu) begin
            for (int i = 0; i < NUM_APU_POLICY; i++) begin
                if (w_dp_aidx == 6'(i)) begin
                    case (r_dp_addr[3:2])
                        2'd0:    r_amid[i]  <= hwdata;
                        2'd1:    r_aaddr[i] <= hwdata;
                        2'd2:    r_amask[i] <= hwdata;
                        default: r_aperm[i] <= hwdata;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int j = 0; j < NUM_DPU_POLICY; j++) begin
                r_dmid[j]   <= '0;
                r_daddr[j]  <= '0;
                r_ddata[j]  <= '0;
                r_dmask[j]  <= '0;
                r_damask[j] <= '0;
            end
        end else if (w_wr_dpu) begin
            for (int j = 0; j < NUM_DPU_POLICY; j++) begin
                if (w_dp_didx == 5'(j)) begin
                    case (r_dp_addr[4:2])
                        3'd0:    r_dmid[j]   <= hwdata;
                        3'd1:    r_daddr[j]  <= hwdata;
                        3'd2:    r_ddata[j]  <= hwdata;
                        3'd3:    r_dmask[j]  <= hwdata;
                        3'd4:    r_damask[j] <= hwdata;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        hrdata = 32'd0;
        if (r_dp_rd) begin
            case (w_dp_kind)
                K_APU: begin
                    for (int i = 0; i < NUM_APU_POLICY; i++) begin
                        if (w_dp_aidx == 6'(i)) begin
                            case (r_dp_addr[3:2])
                                2'd0:    hrdata = r_amid[i];
                                2'd1:    hrdata = r_aaddr[i];
                                2'd2:    hrdata = r_amask[i];
                                default: hrdata = r_aperm[i];
                            endcase
                        end
                    end
                end
                K_DPU: begin
                    for (int j = 0; j < NUM_DPU_POLICY; j++) begin
                        if (w_dp_didx == 5'(j)) begin
                            case (r_dp_addr[4:2])
                                3'd0:    hrdata = r_dmid[j];
                                3'd1:    hrdata = r_daddr[j];
                                3'd2:    hrdata = r_ddata[j];
                                3'd3:    hrdata = r_dmask[j];
                                3'd4:    hrdata = r_damask[j];
                                default: hrdata = 32'd0;
                            endcase
                        end
                    end
                end
                K_CTRL:  hrdata = {31'd0, r_lock};
                K_STAT:  hrdata = {16'd0, r_errcnt, 7'd0, r_lock};
                default: hrdata = 32'd0;   // ERRCLR / COMMIT read as zero
            endcase
        end
    end

    // ---------------- policy outputs ----------------
`ifdef POLICY_SHADOW_EN
    logic [31:0] r_amid_q   [NUM_APU_POLICY];
    logic [31:0] r_aaddr_q  [NUM_APU_POLICY];
    logic [31:0] r_amask_q  [NUM_APU_POLICY];
    logic [31:0] r_aperm_q  [NUM_APU_POLICY];
    logic [31:0] r_dmid_q   [NUM_DPU_POLICY];
    logic [31:0] r_daddr_q  [NUM_DPU_POLICY];
    logic [31:0] r_ddata_q  [NUM_DPU_POLICY];
    logic [31:0] r_dmask_q  [NUM_DPU_POLICY];
    logic [31:0] r_damask_q [NUM_DPU_POLICY];
    logic        w_commit;

    assign w_commit = r_dp_wr && (w_dp_kind == K_COMMIT) && hwdata[0];

    // Whole policy set moves atomically so the monitor never sees a mix.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < NUM_APU_POLICY; i++) begin
                r_amid_q[i]  <= '0;
                r_aaddr_q[i] <= '0;
                r_amask_q[i] <= '0;
                r_aperm_q[i] <= '0;
            end
            for (int j = 0; j < NUM_DPU_POLICY; j++) begin
                r_dmid_q[j]   <= '0;
                r_daddr_q[j]  <= '0;
                r_ddata_q[j]  <= '0;
                r_dmask_q[j]  <= '0;
                r_damask_q[j] <= '0;
            end
        end else if (w_commit) begin
            r_amid_q   <= r_amid;
            r_aaddr_q  <= r_aaddr;
            r_amask_q  <= r_amask;
            r_aperm_q  <= r_aperm;
            r_dmid_q   <= r_dmid;
            r_daddr_q  <= r_daddr;
            r_ddata_q  <= r_ddata;
            r_dmask_q  <= r_dmask;
            r_damask_q <= r_damask;
        end
    end

    assign apumid   = r_amid_q;
    assign apuaddr  = r_aaddr_q;
    assign apumask  = r_amask_q;
    assign apuperm  = r_aperm_q;
    assign dpumid   = r_dmid_q;
    assign dpuaddr  = r_daddr_q;
    assign dpudata  = r_ddata_q;
    assign dpumask  = r_dmask_q;
    assign dpuamask = r_damask_q;
`else
    assign apumid   = r_amid;
    assign apuaddr  = r_aaddr;
    assign apumask  = r_amask;
    assign apuperm  = r_aperm;
    assign dpumid   = r_dmid;
    assign dpuaddr  = r_daddr;
    assign dpudata  = r_ddata;
    assign dpumask  = r_dmask;
    assign dpuamask = r_damask;
`endif

endmodule

// File: tb/tb_ahb_policy_cfg.sv
// ---------------------------------------------------------------------------
// tb_ahb_policy_cfg
//
// Directed bench for ahb_policy_cfg. The driver issues pipelined AHB-lite
// transfers and pushes each transfer's expected response into a queue; an
// independent bus monitor pops and compares whenever a data phase completes.
// Policy outputs are compared directly against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_ahb_policy_cfg;

    localparam int NM = 16;
`ifdef POLICY_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [31:0] hmaster;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    logic [31:0] apumid   [NM];
    logic [31:0] apuaddr  [NM];
    logic [31:0] apumask  [NM];
    logic [31:0] apuperm  [NM];
    logic [31:0] dpumid   [NM];
    logic [31:0] dpuaddr  [NM];
    logic [31:0] dpudata  [NM];
    logic [31:0] dpumask  [NM];
    logic [31:0] dpuamask [NM];

    ahb_policy_cfg #(.NUM_MASTERS(NM)) dut (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .haddr(haddr),
        .hmaster(hmaster), .hsize(hsize), .hwdata(hwdata), .hwrite(hwrite),
        .hrdata(hrdata), .hready(hready), .hresp(hresp),
        .apumid(apumid), .apuaddr(apuaddr), .apumask(apumask), .apuperm(apuperm),
        .dpumid(dpumid), .dpuaddr(dpuaddr), .dpudata(dpudata),
        .dpumask(dpumask), .dpuamask(dpuamask)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        string       nm;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pend_wdata = 32'd0;

    // ---------------- scoreboard monitor ----------------
    logic        mon_pending = 1'b0;
    int          mon_waits   = 0;
    logic        mon_resp1   = 1'b0;

    always @(negedge hclk) begin
        if (!hresetn) begin
            mon_pending = 1'b0;
        end else begin
            if (mon_pending) begin
                if (!hready) begin
                    mon_waits++;
                    mon_resp1 = hresp;
                end else begin
                    mon_pending = 1'b0;
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_response: got resp=%0b rdata=%h, required no transfer", hresp, hrdata);
                    end else begin
                        exp_t x;
                        x = q.pop_front();
                        if (x.err ? !(mon_waits == 1 && mon_resp1 && hresp)
                                  : !(mon_waits == 0 && !hresp)) begin
                            errors++;
                            $display("FAIL %s_resp: got waits=%0d resp=%0b/%0b, required err=%0b", x.nm, mon_waits, mon_resp1, hresp, x.err);
                        end
                        checks++;
                        if (hrdata !== x.rd) begin
                            errors++;
                            $display("FAIL %s_rdata: got %h, required %h", x.nm, hrdata, x.rd);
                        end
                    end
                end
            end
            if (hsel && hready) begin
                mon_pending = 1'b1;
                mon_waits   = 0;
                mon_resp1   = 1'b0;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_accept();
        int n;
        n = 0;
        @(negedge hclk);
        while (!hready && n < 8) begin
            n++;
            @(negedge hclk);
        end
        if (n >= 8) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got hready=0 for %0d cycles, required release", n);
        end
        @(posedge hclk);
        #1;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] m,
                        input logic [2:0] s, input logic [31:0] d,
                        input logic e, input logic [31:0] rd, input string nm);
        exp_t x;
        hsel    = 1'b1;
        hwrite  = w;
        haddr   = a;
        hmaster = m;
        hsize   = s;
        hwdata  = pend_wdata;
        x.err   = e;
        x.rd    = (w || e) ? 32'd0 : rd;
        x.nm    = nm;
        q.push_back(x);
        wait_accept();
        pend_wdata = d;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] m, input logic [31:0] d,
                      input logic e, input string nm);
        xfer(1'b1, a, m, 3'b010, d, e, 32'd0, nm);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] m, input logic e,
                      input logic [31:0] v, input string nm);
        xfer(1'b0, a, m, 3'b010, 32'd0, e, v, nm);
    endtask

    task automatic idle();
        hsel   = 1'b0;
        hwrite = 1'b0;
        haddr  = 32'd0;
        hwdata = pend_wdata;
        wait_accept();
        pend_wdata = 32'd0;
        hwdata     = 32'd0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Expected policy-output value: shadow builds keep the old value until COMMIT.
    function automatic logic [31:0] outv(input logic [31:0] newv, input logic [31:0] oldv);
        return SHADOW ? oldv : newv;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        hresetn = 1'b0;
        hsel = 1'b0; haddr = '0; hmaster = '0; hsize = 3'b010; hwdata = '0; hwrite = 1'b0;
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_hready", {31'd0, hready}, 32'd1);
        chk("rst_hresp",  {31'd0, hresp},  32'd0);
        chk("rst_hrdata", hrdata, 32'd0);
        chk("rst_apuperm0", apuperm[0], 32'd0);
        chk("rst_dpumask0", dpumask[0], 32'd0);
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // basic write / read
        wr(32'h000, 0, 32'h5, 1'b0, "w_apumid0");
        rd(32'h000, 0, 1'b0, 32'h5, "r_apumid0");
        idle();
        chk("apumid0", apumid[0], outv(32'h5, 32'h0));

        // untrusted write
        wr(32'h004, 3, 32'h1234, 1'b1, "w_untrusted");
        idle();
        chk("apuaddr0_kept", apuaddr[0], 32'h0);
        rd(32'h804, 3, 1'b0, 32'h0000_0100, "status_1");
        idle();

        // back-to-back write/read, DPU entry, last APU entry, bounds
        wr(32'h008, 0, 32'hFF, 1'b0, "w_apumask0");
        rd(32'h008, 0, 1'b0, 32'hFF, "r_apumask0");
        wr(32'h430, 1, 32'hA5A5, 1'b0, "w_dpuamask1");
        rd(32'h430, 7, 1'b0, 32'hA5A5, "r_dpuamask1");
        wr(32'h0FC, 0, 32'h7, 1'b0, "w_apuperm15");
        rd(32'h0FC, 0, 1'b0, 32'h7, "r_apuperm15");
        wr(32'h100, 0, 32'h1, 1'b1, "w_apu16");
        rd(32'h414, 0, 1'b1, 32'h0, "r_dpu_rsvd");
        idle();
        chk("apumask0", apumask[0], outv(32'hFF, 32'h0));
        chk("dpuamask1", dpuamask[1], outv(32'hA5A5, 32'h0));
        chk("apuperm15", apuperm[15], outv(32'h7, 32'h0));

        // malformed accesses
        xfer(1'b0, 32'h000, 5, 3'b000, 32'h0, 1'b1, 32'h0, "r_byte");
        rd(32'h002, 5, 1'b1, 32'h0, "r_unaligned");
        rd(32'h7F0, 5, 1'b1, 32'h0, "r_dpu31");
        rd(32'h804, 5, 1'b0, 32'h0000_0600, "status_6");
        wr(32'h808, 0, 32'h0, 1'b0, "errclr_a");
        rd(32'h804, 0, 1'b0, 32'h0, "status_clr_a");

        // saturation
        for (int i = 0; i < 260; i++)
            xfer(1'b0, 32'h000, 5, 3'b000, 32'h0, 1'b1, 32'h0, "r_sat");
        rd(32'h804, 0, 1'b0, 32'h0000_FF00, "status_sat");
        rd(32'h808, 4, 1'b0, 32'h0, "r_errclr");

        // clear racing an error: clear wins
        wr(32'h808, 1, 32'h0, 1'b0, "errclr_b");
        xfer(1'b0, 32'h000, 5, 3'b001, 32'h0, 1'b1, 32'h0, "r_half");
        rd(32'h804, 0, 1'b0, 32'h0, "status_race");
        wr(32'h804, 0, 32'h1, 1'b1, "w_status");
        wr(32'h808, 2, 32'h0, 1'b1, "errclr_untrusted");
        rd(32'h804, 0, 1'b0, 32'h0000_0200, "status_2");

        // lock
        wr(32'h800, 1, 32'h0, 1'b0, "ctrl_w0");
        rd(32'h800, 1, 1'b0, 32'h0, "ctrl_r0");
        wr(32'h808, 0, 32'h0, 1'b0, "errclr_c");
        wr(32'h800, 1, 32'h1, 1'b0, "ctrl_lock");
        wr(32'h40C, 1, 32'h77, 1'b1, "w_locked_dpu");
        idle();
        chk("dpumask0_kept", dpumask[0], 32'h0);
        rd(32'h804, 1, 1'b0, 32'h0000_0101, "status_lock");
        wr(32'h800, 0, 32'h0, 1'b1, "ctrl_w_locked");
        wr(32'h000, 0, 32'h9, 1'b1, "w_locked_apu");
        rd(32'h000, 0, 1'b0, 32'h5, "r_locked_apu");
        wr(32'h808, 0, 32'h0, 1'b0, "errclr_locked");
        rd(32'h804, 0, 1'b0, 32'h0000_0001, "status_locked_clr");
        idle();
        chk("apumid0_locked", apumid[0], outv(32'h5, 32'h0));

        // reset clears everything
        hresetn = 1'b0;
        repeat (2) @(posedge hclk);
        #1;
        chk("rst2_apumid0", apumid[0], 32'h0);
        chk("rst2_apuperm15", apuperm[15], 32'h0);
        chk("rst2_dpuamask1", dpuamask[1], 32'h0);
        hresetn = 1'b1;
        @(posedge hclk); #1;
        rd(32'h800, 0, 1'b0, 32'h0, "ctrl_after_rst");
        rd(32'h0FC, 0, 1'b0, 32'h0, "apuperm15_after_rst");
        wr(32'h000, 0, 32'h42, 1'b0, "w_unlocked");
        rd(32'h000, 0, 1'b0, 32'h42, "r_unlocked");
        idle();

        // reset during a write data phase aborts the update
        hsel = 1'b1; hwrite = 1'b1; haddr = 32'h004; hmaster = 0; hsize = 3'b010;
        @(posedge hclk); #1;
        hsel = 1'b0; hwrite = 1'b0; hwdata = 32'h99; hresetn = 1'b0;
        @(posedge hclk); #1;
        hwdata = 32'h0;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        chk("abort_apuaddr0", apuaddr[0], 32'h0);
        rd(32'h004, 0, 1'b0, 32'h0, "abort_readback");
        idle();

`ifdef POLICY_SHADOW_EN
        wr(32'h00C, 0, 32'h3, 1'b0, "w_sh_perm0");
        rd(32'h00C, 0, 1'b0, 32'h3, "r_sh_perm0");
        idle();
        chk("sh_perm0_held", apuperm[0], 32'h0);
        wr(32'h80C, 4, 32'h1, 1'b1, "commit_untrusted");
        idle();
        chk("sh_perm0_untrusted", apuperm[0], 32'h0);
        wr(32'h80C, 0, 32'h1, 1'b0, "commit");
        idle();
        chk("sh_perm0_commit", apuperm[0], 32'h3);
        rd(32'h80C, 0, 1'b0, 32'h0, "r_commit");
        idle();
`else
        wr(32'h00C, 0, 32'h3, 1'b0, "w_perm0");
        idle();
        chk("perm0_direct", apuperm[0], 32'h3);
        wr(32'h80C, 0, 32'h1, 1'b1, "commit_unmapped");
        rd(32'h80C, 0, 1'b1, 32'h0, "r_commit_unmapped");
        idle();
`endif
        rd(32'h804, 0, 1'b0, SHADOW ? 32'h0000_0100 : 32'h0000_0200, "status_final");
        idle();

        repeat (3) @(posedge hclk);
        #1;
        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required $finish");
        $fatal(1);
    end

endmodule

// File: doc/ahb_policy_cfg.md
Name: ahb_policy_cfg

Overview:
- AHB-lite slave register file that holds the APU/DPU security policies consumed by the transaction monitor.
- Sits behind the monitor's slave port, or on a dedicated configuration bus.
- Drives the apu*/dpu* policy vectors directly.
- Accepts writes only from trusted masters (hmaster[31:1]==0); supports a sticky lock and a saturating error counter.

Parameters:
- NUM_MASTERS, 16, number of bus masters (informational; bounds valid hmaster IDs).
- NUM_APU_POLICY, NUM_MASTERS, APU policy entries; legal range 1..64.
- NUM_DPU_POLICY, NUM_MASTERS, DPU policy entries; legal range 1..32.

Ports:
- hclk  in  1  clock.
- hresetn  in  1  reset; asynchronous, active-low.
- hsel  in  1  slave select.
- haddr  in  32  byte address; only [11:0] decoded.
- hmaster  in  32  requesting master ID.
- hsize  in  3  transfer size.
- hwdata  in  32  write data, valid in the data phase.
- hwrite  in  1  1=write.
- hrdata  out  32  read data.
- hready  out  1  transfer done / stall.
- hresp  out  1  1=ERROR.
- apumid, apuaddr, apumask, apuperm  out  NUM_APU_POLICY x 32 each  APU policy fields.
- dpumid, dpuaddr, dpudata, dpumask, dpuamask  out  NUM_DPU_POLICY x 32 each  DPU policy fields.

Behaviour:
- Address map (haddr[11:0]):
  - APU entry i at 0x000+16*i: +0 mid, +4 addr, +8 mask, +C perm.
  - DPU entry j at 0x400+32*j: +0 mid, +4 addr, +8 data, +C mask, +10 amask; +14..+1C reserved.
  - 0x800 CTRL (RW): bit0 LOCK, sticky.
  - 0x804 STATUS (RO): bit0 LOCK; [15:8] ERRCNT.
  - 0x808 ERRCLR (WO): any accepted write clears ERRCNT.
- Address phase is sampled when hsel & hready. Address, master, size and write are registered and the access is checked in the address phase.
- Error conditions, any of which makes the access illegal:
  - hsize!=3'b010, or haddr[1:0]!=0.
  - Unmapped, reserved, or beyond-NUM_* entry address.
  - Write from hmaster[31:1]!=0.
  - Policy or CTRL write while LOCK=1.
  - Write to STATUS.
- Reads from any master to mapped addresses are legal.
- Legal access: zero wait states.
  - hready=1, hresp=0 in the data phase.
  - Write: register updated from hwdata at the end of the data phase.
  - Read: hrdata is the register value during the data phase; unused bits read 0.
- Illegal access: two-cycle ERROR.
  - Data-phase cycle 1: hready=0, hresp=1.
  - Cycle 2: hready=1, hresp=1.
  - No register changes; ERRCNT increments, saturating at 0xFF.
  - No new address phase is sampled in cycle 1.
- Response FSM: IDLE/OK → ERR1 → ERR2 → IDLE/OK.
  - From ERR2, a new access sampled in that cycle proceeds normally.
- hrdata=0 whenever the data phase is not a legal read.
- Write immediately followed by a read of the same register: the read returns the newly written value.
- LOCK: write of bit0=1 sets it; it clears only on reset. A write of 0 while unlocked is accepted with no effect.
- ERRCLR write and a simultaneous error increment: the clear wins, then increments apply from the next error.
- Reset values: all policy outputs 0 (apuperm=0 ⇒ every non-trusted access is denied by the monitor), LOCK=0, ERRCNT=0, hrdata=0, hready=1, hresp=0, FSM IDLE.
- Reset mid-transfer aborts it with no register update.

Optional Feature:
- Macro POLICY_SHADOW_EN.
- Defined:
  - Policy writes land in shadow registers; outputs are unchanged.
  - A write of 1 to 0x80C COMMIT copies all shadows to the outputs in one cycle, visible the cycle after the COMMIT data phase.
  - Policy-address reads return shadow values. COMMIT reads 0 and obeys the lock and trust rules.
- Undefined:
  - Writes update outputs directly.
  - 0x80C is unmapped and returns ERROR.

Test Plan:
- Master 0 writes 0x000=0x5, then reads 0x000 → OKAY, zero wait; apumid[0]=0x5; hrdata=0x5.
- Master 3 writes 0x004=0x1234 → hready 0/1 with hresp 1/1; apuaddr[0] unchanged=0; STATUS[15:8]=1.
- Master 1 writes CTRL=1, then writes 0x40C → ERROR; dpumask[0] unchanged; STATUS=0x0000_0101. Reset → LOCK=0 and all outputs 0.
- Malformed accesses: byte read (hsize=0) at 0x000, word read at 0x002, and read at 0x7F0 with NUM_DPU_POLICY=16 → each ERROR. Then 256+ errors → ERRCNT=0xFF. ERRCLR write → 0.
- Back-to-back write 0x008=0xFF then read 0x008 → read data phase returns 0xFF, no stall.
- With POLICY_SHADOW_EN: write 0x00C=0x3 → apuperm[0] stays 0. Write COMMIT=1 → apuperm[0]=0x3 the next cycle.
